// File: rtl/yarp_pkg.sv
// Shared definitions for the YARP branch resolution unit: branch funct3 encodings,
// BHT counter reset value and BHT index extraction.
package yarp_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_func3_e;

    // Weakly-not-taken: one below the MSB-set midpoint of the counter range.
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned bht_idx(input logic [63:0] pc, input int unsigned entries);
        logic [31:0] word;
        word = pc[33:2];
        return word & (entries - 32'd1);
    endfunction

endpackage

// File: rtl/yarp_bht.sv
// Direct-mapped table of saturating prediction counters with a combinational
// read port for fetch and a synchronous update port for execute.
module yarp_bht
    import yarp_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx_i,
    output logic                           rd_pred_o,
    input  logic                           upd_en_i,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx_i,
    input  logic                           upd_taken_i
);

    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];
    logic [CTR_BITS-1:0] upd_cur;
    logic [CTR_BITS-1:0] ctr_d;

    // Read returns the stored value, so a same-cycle update is seen next cycle.
    assign rd_pred_o = ctr_q[rd_idx_i][CTR_BITS-1];
    assign upd_cur   = ctr_q[upd_idx_i];

    always_comb begin
        ctr_d = upd_cur;
        if (upd_taken_i) begin
            if (upd_cur != CTR_MAX) begin
                ctr_d = upd_cur + CTR_BITS'(1);
            end
        end else begin
            if (upd_cur != '0) begin
                ctr_d = upd_cur - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/yarp_branch_unit.sv
// Execute-stage branch resolution: compares operands, registers the outcome and
// redirect PC, trains the BHT and keeps saturating branch/mispredict statistics.
module yarp_branch_unit
    import yarp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int STAT_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid_i,
    input  logic                 is_b_type_ctl_i,
    input  logic [2:0]           instr_func3_ctl_i,
    input  logic [XLEN-1:0]      opr_a_i,
    input  logic [XLEN-1:0]      opr_b_i,
    input  logic [XLEN-1:0]      ex_pc_i,
    input  logic [XLEN-1:0]      ex_target_i,
    input  logic                 ex_pred_taken_i,
    input  logic                 flush_i,
    input  logic [XLEN-1:0]      fe_pc_i,
    output logic                 fe_pred_taken_o,
    output logic                 res_valid_o,
    output logic                 branch_taken_o,
    output logic                 mispredict_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic [STAT_BITS-1:0] branch_cnt_o,
    output logic [STAT_BITS-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic             is_eq;
    logic             lt_s;
    logic             lt_u;
    logic             taken;
    logic             legal;
    logic             resolve;
    logic             mispred;
    logic [XLEN-1:0]  redirect_pc;
    logic [IDX_W-1:0] fe_idx;
    logic [IDX_W-1:0] ex_idx;

    logic                 res_valid_q;
    logic                 taken_q;
    logic                 mispred_q;
    logic [XLEN-1:0]      redirect_q;
    logic [STAT_BITS-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_BITS-1:0] mispred_cnt_q, mispred_cnt_d;

    assign is_eq = (opr_a_i == opr_b_i);
    assign lt_s  = ($signed(opr_a_i) < $signed(opr_b_i));
    assign lt_u  = (opr_a_i < opr_b_i);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (instr_func3_ctl_i)
            BR_BEQ:  taken = is_eq;
            BR_BNE:  taken = ~is_eq;
            BR_BLT:  taken = lt_s;
            BR_BGE:  taken = ~lt_s;
            BR_BLTU: taken = lt_u;
            BR_BGEU: taken = ~lt_u;
            default: legal = 1'b0;
        endcase
    end

    assign resolve     = ex_valid_i & is_b_type_ctl_i & legal & ~flush_i;
    assign mispred     = taken ^ ex_pred_taken_i;
    assign redirect_pc = taken ? ex_target_i : (ex_pc_i + XLEN'(4));

    assign fe_idx = IDX_W'(bht_idx(64'(fe_pc_i), BHT_ENTRIES));
    assign ex_idx = IDX_W'(bht_idx(64'(ex_pc_i), BHT_ENTRIES));

    yarp_bht #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_BITS    (CTR_BITS)
    ) u_bht (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (fe_idx),
        .rd_pred_o   (fe_pred_taken_o),
        .upd_en_i    (resolve),
        .upd_idx_i   (ex_idx),
        .upd_taken_i (taken)
    );

    // Statistics stick at all-ones rather than wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + STAT_BITS'(1);
        end
        if (resolve && mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_q   <= 1'b0;
            taken_q       <= 1'b0;
            mispred_q     <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_valid_q   <= resolve;
            mispred_q     <= resolve & mispred;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (resolve) begin
                taken_q    <= taken;
                redirect_q <= redirect_pc;
            end
        end
    end

    assign res_valid_o    = res_valid_q;
    assign branch_taken_o = taken_q;
    assign mispredict_o   = mispred_q;
    assign redirect_pc_o  = redirect_q;
    assign branch_cnt_o   = branch_cnt_q;
    assign mispred_cnt_o  = mispred_cnt_q;

endmodule
